// File: rtl/mlp_seq_pkg.sv
// Shared types and sizes for the MLP feature sequencer.
// State encoding, feature index width and settle counter width.
package mlp_seq_pkg;

    localparam int N_FEAT_DEF = 4;
    localparam int IDX_W      = $clog2(N_FEAT_DEF);
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SETTLE = 2'd1,
        RESULT = 2'd2
    } seq_state_e;

endpackage

// File: rtl/mlp_seq_settle_cnt.sv
// Load/decrement down-counter timing the core settle window.
// Holds at zero and flags it to the sequencer FSM.
module mlp_seq_settle_cnt
    import mlp_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mlp_feature_sequencer.sv
// Clocked front/back end for the combinational MLP classifier core.
// Define MLP_SEQ_PREDO_EN to also capture and expose the raw core scores.
module mlp_feature_sequencer
    import mlp_seq_pkg::*;
#(
    parameter int N_FEAT     = N_FEAT_DEF,
    parameter int FEAT_W     = 4,
    parameter int CLS_W      = 2,
    parameter int PRED_W     = 57,
    parameter int SETTLE_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     feat_valid,
    output logic                     feat_ready,
    input  logic [FEAT_W-1:0]        feat_data,
    input  logic                     feat_last,
    output logic [N_FEAT*FEAT_W-1:0] clf_inp,
    input  logic [CLS_W-1:0]         clf_out,
    input  logic [PRED_W-1:0]        clf_predo,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [CLS_W-1:0]         res_class,
`ifdef MLP_SEQ_PREDO_EN
    output logic [PRED_W-1:0]        res_predo,
`endif
    output logic                     frame_err
);

    seq_state_e state;
    seq_state_e state_nxt;

    logic [IDX_W-1:0]         idx;
    logic [N_FEAT*FEAT_W-1:0] shadow;
    logic [N_FEAT*FEAT_W-1:0] merged;

    logic accept;
    logic last_slot;
    logic beat_ok;
    logic commit;
    logic bad;
    logic capture;
    logic res_done;
    logic cnt_zero;

    assign accept    = feat_valid & feat_ready;
    assign last_slot = (idx == IDX_W'(N_FEAT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        feat_ready = 1'b0;
        beat_ok    = 1'b0;
        commit     = 1'b0;
        bad        = 1'b0;
        capture    = 1'b0;
        res_done   = 1'b0;
        unique case (state)
            FILL: begin
                feat_ready = !rst;
                if (accept) begin
                    if (last_slot && feat_last) begin
                        commit    = 1'b1;
                        state_nxt = SETTLE;
                    end else if (!last_slot && !feat_last) begin
                        beat_ok = 1'b1;
                    end else begin
                        bad = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (cnt_zero) begin
                    capture   = 1'b1;
                    state_nxt = RESULT;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    res_done  = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    mlp_seq_settle_cnt u_settle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (commit),
        .load_val (CNT_W'(SETTLE_CYC - 1)),
        .dec      (state == SETTLE),
        .zero     (cnt_zero)
    );

    always_comb begin
        merged = shadow;
        merged[int'(idx)*FEAT_W +: FEAT_W] = feat_data;
    end

    // Malformed beats leave shadow and clf_inp alone; only idx rewinds.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            shadow    <= '0;
            clf_inp   <= '0;
            frame_err <= 1'b0;
            res_valid <= 1'b0;
            res_class <= '0;
        end else begin
            frame_err <= bad;
            if (beat_ok) begin
                shadow <= merged;
                idx    <= idx + 1'b1;
            end
            if (bad) begin
                idx <= '0;
            end
            if (commit) begin
                shadow  <= merged;
                clf_inp <= merged;
            end
            if (capture) begin
                res_class <= clf_out;
                res_valid <= 1'b1;
            end
            if (res_done) begin
                res_valid <= 1'b0;
                idx       <= '0;
            end
        end
    end

`ifdef MLP_SEQ_PREDO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            res_predo <= '0;
        end else if (capture) begin
            res_predo <= clf_predo;
        end
    end
`else
    logic predo_unused;
    assign predo_unused = ^clf_predo;
`endif

endmodule

// File: tb/tb_mlp_feature_sequencer.sv
// Self-checking bench for mlp_feature_sequencer with a stub classifier core.
// Build with MLP_SEQ_PREDO_EN defined to also cover the raw score capture.
module tb_mlp_feature_sequencer;

    localparam int SETTLE_CYC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        feat_valid;
    logic        feat_ready;
    logic [3:0]  feat_data;
    logic        feat_last;
    logic [15:0] clf_inp;
    logic [1:0]  clf_out;
    logic [56:0] clf_predo;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_class;
    logic [56:0] res_predo_w;
    logic        frame_err;

    logic        predo_fix_en;
    logic [56:0] predo_fix;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mlp_feature_sequencer #(.SETTLE_CYC(SETTLE_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .feat_valid (feat_valid),
        .feat_ready (feat_ready),
        .feat_data  (feat_data),
        .feat_last  (feat_last),
        .clf_inp    (clf_inp),
        .clf_out    (clf_out),
        .clf_predo  (clf_predo),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_class  (res_class),
`ifdef MLP_SEQ_PREDO_EN
        .res_predo  (res_predo_w),
`endif
        .frame_err  (frame_err)
    );

`ifndef MLP_SEQ_PREDO_EN
    assign res_predo_w = '0;
`endif

    // Stub core: class = feature sum mod 4, scores derived from the input.
    always_comb begin
        clf_out   = 2'(clf_inp[3:0] + clf_inp[7:4] + clf_inp[11:8] + clf_inp[15:12]);
        clf_predo = predo_fix_en ? predo_fix : {9'h1A5, clf_inp, ~clf_inp, clf_inp};
    end

    function automatic logic [1:0] model_class(input logic [15:0] v);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) s += int'(v[i*4 +: 4]);
        return 2'(s % 4);
    endfunction

    function automatic logic [56:0] model_predo(input logic [15:0] v);
        return {9'h1A5, v, ~v, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [3:0] d, input logic l);
        int waited;
        feat_valid = 1'b1;
        feat_data  = d;
        feat_last  = l;
        waited = 0;
        while (!feat_ready && waited < 50) begin
            step();
            waited++;
        end
        if (!feat_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_timeout: feat_ready=%0b required=1", feat_ready);
        end else begin
            step();
        end
        feat_valid = 1'b0;
        feat_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] v);
        for (int i = 0; i < 4; i++) send_beat(v[i*4 +: 4], i == 3);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++;
        if (feat_ready !== 1'b0 || res_valid !== 1'b0 || frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: ready=%0b valid=%0b err=%0b required 0/0/0",
                     feat_ready, res_valid, frame_err);
        end
        vectors++;
        if (clf_inp !== 16'h0 || res_class !== 2'd0 || res_predo_w !== '0) begin
            miscompares++;
            $display("FAIL reset_data: inp=%h cls=%0d predo=%h required 0",
                     clf_inp, res_class, res_predo_w);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (feat_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got=%0b required=1", feat_ready);
        end
    endtask

    task automatic test_basic();
        send_frame(16'h4321);
        vectors++;
        if (clf_inp !== 16'h4321 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_commit: inp=%h valid=%0b required 4321/0", clf_inp, res_valid);
        end
        for (int k = 1; k < SETTLE_CYC; k++) begin
            step();
            vectors++;
            if (res_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_early_valid: got=%0b required=0", res_valid);
            end
        end
        step();
        vectors++;
        if (res_valid !== 1'b1 || res_class !== 2'b10) begin
            miscompares++;
            $display("FAIL basic_result: valid=%0b cls=%0d required 1/2", res_valid, res_class);
        end
        handshake();
        vectors++;
        if (res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_release: valid=%0b required=0", res_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] v;
        logic [1:0]  c;
        v = 16'($urandom);
        c = model_class(v);
        send_frame(v);
        for (int k = 0; k < SETTLE_CYC; k++) step();
        feat_valid = 1'b1;
        feat_data  = 4'h5;
        feat_last  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (feat_ready !== 1'b0 || res_valid !== 1'b1 || res_class !== c) begin
                miscompares++;
                $display("FAIL bp_hold: ready=%0b valid=%0b cls=%0d required 0/1/%0d",
                         feat_ready, res_valid, res_class, c);
            end
            step();
        end
        res_ready = 1'b1;
        #1;
        vectors++;
        if (feat_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_same_cycle_ready: got=%0b required=0", feat_ready);
        end
        step();
        res_ready  = 1'b0;
        feat_valid = 1'b0;
        vectors++;
        if (res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_valid_drop: got=%0b required=0", res_valid);
        end
        step();
        vectors++;
        if (feat_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_ready_return: got=%0b required=1", feat_ready);
        end
    endtask

    task automatic test_short_frame();
        logic [15:0] prev;
        prev = clf_inp;
        send_beat(4'h5, 1'b0);
        send_beat(4'h6, 1'b1);
        vectors++;
        if (frame_err !== 1'b1 || clf_inp !== prev) begin
            miscompares++;
            $display("FAIL short_err: err=%0b inp=%h required 1/%h", frame_err, clf_inp, prev);
        end
        step();
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL short_pulse_width: err=%0b required=0", frame_err);
        end
        send_frame(16'hA987);
        vectors++;
        if (clf_inp !== 16'hA987) begin
            miscompares++;
            $display("FAIL short_recover_inp: got=%h required=a987", clf_inp);
        end
        for (int k = 0; k < SETTLE_CYC; k++) step();
        vectors++;
        if (res_valid !== 1'b1 || res_class !== model_class(16'hA987)) begin
            miscompares++;
            $display("FAIL short_recover_cls: valid=%0b cls=%0d required 1/%0d",
                     res_valid, res_class, model_class(16'hA987));
        end
        handshake();
    endtask

    task automatic test_long_frame();
        logic [15:0] prev;
        prev = clf_inp;
        for (int i = 0; i < 3; i++) send_beat(4'(i + 1), 1'b0);
        send_beat(4'hC, 1'b0);
        vectors++;
        if (frame_err !== 1'b1 || clf_inp !== prev) begin
            miscompares++;
            $display("FAIL long_err: err=%0b inp=%h required 1/%h", frame_err, clf_inp, prev);
        end
        send_beat(4'hD, 1'b1);
        vectors++;
        if (frame_err !== 1'b1) begin
            miscompares++;
            $display("FAIL long_then_last_at_idx0: err=%0b required=1", frame_err);
        end
        for (int k = 0; k < SETTLE_CYC + 2; k++) begin
            step();
            vectors++;
            if (res_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL long_no_result: valid=%0b required=0", res_valid);
            end
        end
        send_frame(16'h5EB1);
        vectors++;
        if (clf_inp !== 16'h5EB1) begin
            miscompares++;
            $display("FAIL long_recover_inp: got=%h required=5eb1", clf_inp);
        end
        for (int k = 0; k < SETTLE_CYC; k++) step();
        handshake();
    endtask

    task automatic test_reset_mid();
        send_frame(16'h1234);
        rst = 1'b1;
        step();
        vectors++;
        if (res_valid !== 1'b0 || clf_inp !== 16'h0 || feat_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid: valid=%0b inp=%h ready=%0b required 0/0000/0",
                     res_valid, clf_inp, feat_ready);
        end
        step();
        step();
        vectors++;
        if (res_valid !== 1'b0 || feat_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_hold: valid=%0b ready=%0b required 0/0", res_valid, feat_ready);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (feat_ready !== 1'b1 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_release: ready=%0b valid=%0b required 1/0", feat_ready, res_valid);
        end
    endtask

`ifdef MLP_SEQ_PREDO_EN
    task automatic test_predo();
        logic [56:0] want;
        want         = 57'h1_2345_6789_ABCD;
        predo_fix    = want;
        predo_fix_en = 1'b1;
        send_frame(16'h2468);
        for (int k = 0; k < SETTLE_CYC; k++) step();
        vectors++;
        if (res_valid !== 1'b1 || res_predo_w !== want) begin
            miscompares++;
            $display("FAIL predo_capture: valid=%0b predo=%h required 1/%h",
                     res_valid, res_predo_w, want);
        end
        predo_fix = ~want;
        step();
        step();
        vectors++;
        if (res_predo_w !== want) begin
            miscompares++;
            $display("FAIL predo_hold: got=%h required=%h", res_predo_w, want);
        end
        handshake();
        predo_fix_en = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [3:0]  sh [4];
        logic [15:0] exp_inp;
        int          cnt;
        logic [3:0]  d;
        logic        l;
        logic        exp_err;
        logic        fire;
        cnt     = 0;
        exp_inp = clf_inp;
        for (int n = 0; n < 120; n++) begin
            d = 4'($urandom_range(0, 15));
            if (cnt == 3) l = ($urandom_range(0, 4) != 0);
            else          l = ($urandom_range(0, 5) == 0);
            fire    = 1'b0;
            exp_err = 1'b0;
            if (cnt == 3 && l) begin
                exp_inp = {d, sh[2], sh[1], sh[0]};
                fire    = 1'b1;
                cnt     = 0;
            end else if (cnt < 3 && !l) begin
                sh[cnt] = d;
                cnt++;
            end else begin
                exp_err = 1'b1;
                cnt     = 0;
            end
            send_beat(d, l);
            vectors++;
            if (frame_err !== exp_err || clf_inp !== exp_inp) begin
                miscompares++;
                $display("FAIL rand_beat%0d: err=%0b inp=%h required %0b/%h",
                         n, frame_err, clf_inp, exp_err, exp_inp);
            end
            if (fire) begin
                for (int k = 1; k < SETTLE_CYC; k++) step();
                vectors++;
                if (res_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_early%0d: valid=%0b required=0", n, res_valid);
                end
                step();
                vectors++;
                if (res_valid !== 1'b1 || res_class !== model_class(exp_inp)) begin
                    miscompares++;
                    $display("FAIL rand_result%0d: valid=%0b cls=%0d required 1/%0d",
                             n, res_valid, res_class, model_class(exp_inp));
                end
`ifdef MLP_SEQ_PREDO_EN
                vectors++;
                if (res_predo_w !== model_predo(exp_inp)) begin
                    miscompares++;
                    $display("FAIL rand_predo%0d: got=%h required=%h",
                             n, res_predo_w, model_predo(exp_inp));
                end
`endif
                repeat ($urandom_range(0, 3)) step();
                handshake();
                vectors++;
                if (res_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_release%0d: valid=%0b required=0", n, res_valid);
                end
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        feat_valid   = 1'b0;
        feat_data    = 4'h0;
        feat_last    = 1'b0;
        res_ready    = 1'b0;
        predo_fix_en = 1'b0;
        predo_fix    = '0;
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_short_frame();
        test_long_frame();
        test_reset_mid();
`ifdef MLP_SEQ_PREDO_EN
        test_predo();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
